// File: rtl/im_loader_if.sv
// Byte-stream handshake plus instruction-memory write bus for the boot loader.
// The loader takes the master side; the byte source and memory take the slave side.
interface im_loader_if;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        wr_en;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;

  modport master (
    input  byte_valid, byte_data,
    output byte_ready, wr_en, wr_addr, wr_data
  );

  modport slave (
    output byte_valid, byte_data,
    input  byte_ready, wr_en, wr_addr, wr_data
  );
endinterface

// File: rtl/im_loader.sv
// Boot-time instruction-memory loader: length-prefixed big-endian word stream
// with an XOR checksum; holds the CPU until a verified image is in place.
module im_loader #(
  parameter int          ADDR_W    = 8,
  parameter logic [31:0] BASE_ADDR = 32'h0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  im_loader_if.master bus,
  output logic        cpu_hold,
  output logic        done,
  output logic        error
);

  typedef enum logic [2:0] {
    S_IDLE, S_LEN_HI, S_LEN_LO, S_DATA, S_CSUM, S_DONE, S_ERR
  } state_t;

  // Largest legal word count; any ADDR_W of 16 or more admits every 16-bit N.
  localparam logic [16:0] MAX_N = (ADDR_W >= 16) ? 17'h10000 : 17'(1 << ADDR_W);

  state_t              state_q, state_d;
  logic [15:0]         len_q, len_d;
  logic [1:0]          bcnt_q, bcnt_d;
  logic [ADDR_W:0]     idx_q, idx_d;
  logic [7:0]          xor_q, xor_d;
  logic [23:0]         word_q, word_d;
  logic                byte_ready_q, byte_ready_d;
  logic                wr_en_q, wr_en_d;
  logic [31:0]         wr_addr_q, wr_addr_d;
  logic [31:0]         wr_data_q, wr_data_d;
  logic                cpu_hold_q, cpu_hold_d;
  logic                done_q, done_d;
  logic                error_q, error_d;

  logic                accept;
  logic [15:0]         len_full;

  assign accept   = bus.byte_valid && byte_ready_q;
  assign len_full = {len_q[15:8], bus.byte_data};

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    bcnt_d     = bcnt_q;
    idx_d      = idx_q;
    xor_d      = xor_q;
    word_d     = word_q;
    wr_en_d    = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    cpu_hold_d = cpu_hold_q;
    done_d     = done_q;
    error_d    = error_q;

    unique case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          state_d    = S_LEN_HI;
          bcnt_d     = '0;
          idx_d      = '0;
          xor_d      = '0;
          done_d     = 1'b0;
          error_d    = 1'b0;
          cpu_hold_d = 1'b1;
        end
      end
      S_LEN_HI: begin
        if (accept) begin
          len_d   = {bus.byte_data, 8'h00};
          state_d = S_LEN_LO;
        end
      end
      S_LEN_LO: begin
        if (accept) begin
          len_d = len_full;
          if ({1'b0, len_full} > MAX_N) begin
            state_d = S_ERR;
            error_d = 1'b1;
          end else if (len_full == 16'h0) begin
            state_d = S_CSUM;
          end else begin
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (accept) begin
          word_d = {word_q[15:0], bus.byte_data};
          xor_d  = xor_q ^ bus.byte_data;
          bcnt_d = bcnt_q + 2'd1;
          if (bcnt_q == 2'd3) begin
            wr_en_d   = 1'b1;
            wr_data_d = {word_q, bus.byte_data};
            wr_addr_d = BASE_ADDR + (32'(idx_q) << 2);
            idx_d     = idx_q + 1'b1;
            // Leaving on the last word's final byte lets CSUM take the very next byte.
            if (32'(idx_q) + 32'd1 == 32'(len_q)) state_d = S_CSUM;
          end
        end
      end
      S_CSUM: begin
        if (accept) begin
          if (bus.byte_data == xor_q) begin
            state_d    = S_DONE;
            done_d     = 1'b1;
            cpu_hold_d = 1'b0;
          end else begin
            state_d = S_ERR;
            error_d = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    byte_ready_d = (state_d == S_LEN_HI) || (state_d == S_LEN_LO) ||
                   (state_d == S_DATA)   || (state_d == S_CSUM);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      len_q        <= '0;
      bcnt_q       <= '0;
      idx_q        <= '0;
      xor_q        <= '0;
      word_q       <= '0;
      byte_ready_q <= 1'b0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      cpu_hold_q   <= 1'b1;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      bcnt_q       <= bcnt_d;
      idx_q        <= idx_d;
      xor_q        <= xor_d;
      word_q       <= word_d;
      byte_ready_q <= byte_ready_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      cpu_hold_q   <= cpu_hold_d;
      done_q       <= done_d;
      error_q      <= error_d;
    end
  end

  assign bus.byte_ready = byte_ready_q;
  assign bus.wr_en      = wr_en_q;
  assign bus.wr_addr    = wr_addr_q;
  assign bus.wr_data    = wr_data_q;
  assign cpu_hold       = cpu_hold_q;
  assign done           = done_q;
  assign error          = error_q;

endmodule

// File: tb/tb_im_loader.sv
// Directed bench for im_loader: two instances, default base and base 0x100,
// with hand-computed write addresses, data and status expectations.
module tb_im_loader;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic start0 = 1'b0, start1 = 1'b0;
  logic hold0, done0, err0, hold1, done1, err1;

  im_loader_if bus0 ();
  im_loader_if bus1 ();

  im_loader #(.ADDR_W(8), .BASE_ADDR(32'h0)) dut0 (
    .clock(clock), .reset(reset), .start(start0), .bus(bus0.master),
    .cpu_hold(hold0), .done(done0), .error(err0)
  );

  im_loader #(.ADDR_W(8), .BASE_ADDR(32'h100)) dut1 (
    .clock(clock), .reset(reset), .start(start1), .bus(bus1.master),
    .cpu_hold(hold1), .done(done1), .error(err1)
  );

  always #5 clock = ~clock;

  int cmp = 0;
  int errs = 0;

  // Free-running monitors sampled on the falling edge, away from the active edge.
  int          wcnt0 = 0, wcnt1 = 0, acc1 = 0;
  logic [31:0] last_addr1 = '0, last_data1 = '0;
  always @(negedge clock) begin
    if (bus0.wr_en) wcnt0++;
    if (bus1.wr_en) begin
      wcnt1++;
      last_addr1 = bus1.wr_addr;
      last_data1 = bus1.wr_data;
    end
    if (bus1.byte_valid && bus1.byte_ready) acc1++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    cmp++;
    assert (got === exp) else begin
      errs++;
      $error("FAIL %s: got=%0h want=%0h", tag, got, exp);
    end
  endtask

  // Called at posedge+1; returns at posedge+1 right after the accepting edge.
  task automatic send0(input logic [7:0] b);
    int n = 0;
    bus0.byte_valid = 1'b1;
    bus0.byte_data  = b;
    @(negedge clock);
    while (!bus0.byte_ready && n < 20) begin
      @(negedge clock);
      n++;
    end
    if (!bus0.byte_ready) chk("send0_timeout", 32'(bus0.byte_ready), 32'h1);
    @(posedge clock);
    #1;
    bus0.byte_valid = 1'b0;
  endtask

  // Valid high for the accepting cycle, then one idle cycle.
  task automatic send1(input logic [7:0] b);
    int n = 0;
    bus1.byte_valid = 1'b1;
    bus1.byte_data  = b;
    @(negedge clock);
    while (!bus1.byte_ready && n < 20) begin
      @(negedge clock);
      n++;
    end
    if (!bus1.byte_ready) chk("send1_timeout", 32'(bus1.byte_ready), 32'h1);
    @(posedge clock);
    #1;
    bus1.byte_valid = 1'b0;
    @(posedge clock);
    #1;
  endtask

  task automatic pulse_start0();
    start0 = 1'b1;
    @(posedge clock);
    #1;
    start0 = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_rdy"},   32'(bus0.byte_ready), 32'h0);
    chk({tag, "_wen"},   32'(bus0.wr_en), 32'h0);
    chk({tag, "_waddr"}, bus0.wr_addr, 32'h0);
    chk({tag, "_wdata"}, bus0.wr_data, 32'h0);
    chk({tag, "_hold"},  32'(hold0), 32'h1);
    chk({tag, "_done"},  32'(done0), 32'h0);
    chk({tag, "_err"},   32'(err0), 32'h0);
  endtask

  // Two-word image; checksum A8 = 24^08^00^05^8C^09^00^04.
  task automatic two_word_image(input string tag, input logic [7:0] csum);
    send0(8'h00); send0(8'h02);
    send0(8'h24); send0(8'h08); send0(8'h00); send0(8'h05);
    chk({tag, "_w0_en"},   32'(bus0.wr_en), 32'h1);
    chk({tag, "_w0_addr"}, bus0.wr_addr, 32'h0);
    chk({tag, "_w0_data"}, bus0.wr_data, 32'h24080005);
    send0(8'h8C); send0(8'h09); send0(8'h00); send0(8'h04);
    chk({tag, "_w1_en"},   32'(bus0.wr_en), 32'h1);
    chk({tag, "_w1_addr"}, bus0.wr_addr, 32'h4);
    chk({tag, "_w1_data"}, bus0.wr_data, 32'h8C090004);
    send0(csum);
    chk({tag, "_csum_nowen"}, 32'(bus0.wr_en), 32'h0);
  endtask

  int w0;

  initial begin
    bus0.byte_valid = 1'b0; bus0.byte_data = 8'h00;
    bus1.byte_valid = 1'b0; bus1.byte_data = 8'h00;

    // Reset state
    #12;
    check_reset_vals("rst");
    chk("rst1_hold", 32'(hold1), 32'h1);
    chk("rst1_rdy",  32'(bus1.byte_ready), 32'h0);
    @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock); #1;
    chk("idle_rdy", 32'(bus0.byte_ready), 32'h0);

    // Good two-word image
    pulse_start0();
    chk("t1_rdy_after_start", 32'(bus0.byte_ready), 32'h1);
    w0 = wcnt0;
    two_word_image("t1", 8'hA8);
    chk("t1_done", 32'(done0), 32'h1);
    chk("t1_hold", 32'(hold0), 32'h0);
    chk("t1_err",  32'(err0), 32'h0);
    chk("t1_rdy",  32'(bus0.byte_ready), 32'h0);
    chk("t1_wcnt", 32'(wcnt0 - w0), 32'd2);

    // Same image with a bad checksum
    pulse_start0();
    chk("t2_done_clr", 32'(done0), 32'h0);
    chk("t2_hold_set", 32'(hold0), 32'h1);
    w0 = wcnt0;
    two_word_image("t2", 8'h00);
    chk("t2_err",  32'(err0), 32'h1);
    chk("t2_done", 32'(done0), 32'h0);
    chk("t2_hold", 32'(hold0), 32'h1);
    chk("t2_wcnt", 32'(wcnt0 - w0), 32'd2);

    // Empty image: length 0 then checksum 0
    pulse_start0();
    chk("t3_err_clr", 32'(err0), 32'h0);
    w0 = wcnt0;
    send0(8'h00); send0(8'h00);
    chk("t3_not_done_yet", 32'(done0), 32'h0);
    send0(8'h00);
    chk("t3_done", 32'(done0), 32'h1);
    chk("t3_hold", 32'(hold0), 32'h0);
    chk("t3_wcnt", 32'(wcnt0 - w0), 32'd0);

    // Oversize length 257 with ADDR_W=8
    pulse_start0();
    w0 = wcnt0;
    send0(8'h01); send0(8'h01);
    chk("t4_err",  32'(err0), 32'h1);
    chk("t4_rdy",  32'(bus0.byte_ready), 32'h0);
    chk("t4_hold", 32'(hold0), 32'h1);
    @(posedge clock); #1;
    chk("t4_wcnt", 32'(wcnt0 - w0), 32'd0);

    // Base 0x100, valid toggling; checksum 08 = 12^34^56^78
    start1 = 1'b1;
    @(posedge clock); #1;
    start1 = 1'b0;
    acc1 = 0;
    send1(8'h00); send1(8'h01);
    send1(8'h12); send1(8'h34); send1(8'h56); send1(8'h78);
    send1(8'h08);
    chk("t5_wcnt", 32'(wcnt1), 32'd1);
    chk("t5_addr", last_addr1, 32'h100);
    chk("t5_data", last_data1, 32'h12345678);
    chk("t5_acc",  32'(acc1), 32'd7);
    chk("t5_done", 32'(done1), 32'h1);

    // Reset in the middle of a load, then a full reload
    pulse_start0();
    send0(8'h00); send0(8'h02);
    send0(8'h24); send0(8'h08); send0(8'h00); send0(8'h05);
    send0(8'h8C); send0(8'h09);
    #2;
    reset = 1'b0;
    #1;
    check_reset_vals("t6_rst");
    @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock); #1;
    pulse_start0();
    w0 = wcnt0;
    two_word_image("t6", 8'hA8);
    chk("t6_done", 32'(done0), 32'h1);
    chk("t6_hold", 32'(hold0), 32'h0);
    chk("t6_wcnt", 32'(wcnt0 - w0), 32'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, errs);
    $finish;
  end

endmodule
